btn_input: RTL

BTN_INPUT -- requirements
Module: btn_input

---
 rtl/btn_input_pkg.sv | 12 +
 rtl/btn_debounce.sv | 57 +++++
 rtl/btn_input.sv | 103 ++++++++++
 3 files changed

// File: rtl/btn_input_pkg.sv
// Shared types and register offsets for the push-button input peripheral.
package btn_input_pkg;

  typedef logic [7:0] btn_t;
  typedef logic [3:0] wrstb_t;

  localparam logic [1:0] BTN_REG_STATE = 2'd0;
  localparam logic [1:0] BTN_REG_RISE  = 2'd1;
  localparam logic [1:0] BTN_REG_FALL  = 2'd2;
  localparam logic [1:0] BTN_REG_MASK  = 2'd3;

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-FF synchronizer, inversion to active-high, debounce counter.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic state,
  output logic rise,
  output logic fall
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          synced;
  logic          accept;

  assign synced = ~sync2_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    accept  = 1'b0;
    if (synced != state_q) begin
      if (cnt_q == CNT_MAX) begin
        accept  = 1'b1;
        state_d = synced;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchronizer resets to released so a held button is seen as a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state = state_q;
  assign rise  = accept & synced;
  assign fall  = accept & ~synced;

endmodule

// File: rtl/btn_input.sv
// Button peripheral: debounced state, sticky edge flags (W1C), irq mask.
module btn_input
  import btn_input_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 27_000_000,
  parameter int DEBOUNCE_CYCLES = CLOCK_FREQUENCY / 100,
  parameter int N_BTN           = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_n,
  input  logic             sel,
  input  logic [31:0]      addr,
  input  logic [31:0]      wrdata,
  input  wrstb_t           wrstb,
  output logic [31:0]      rddata,
  output logic             irq
);

  logic [N_BTN-1:0] state, rise_ev, fall_ev;
  logic [N_BTN-1:0] rise_q, rise_d;
  logic [N_BTN-1:0] fall_q, fall_d;
  logic [N_BTN-1:0] mask_q, mask_d;
  logic [N_BTN-1:0] rise_clr, fall_clr;
  logic [N_BTN-1:0] wbits, rd_bits;
  logic [31:0]      rddata_q, rddata_d;
  logic             irq_q, irq_d;
  logic             we;
  logic [1:0]       reg_sel;
  logic             unused_bits;

  assign unused_bits = ^{addr[31:4], addr[1:0], wrdata, wrstb[3:1]};

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk  (clk),
      .rst  (rst),
      .btn_n(btn_n[g]),
      .state(state[g]),
      .rise (rise_ev[g]),
      .fall (fall_ev[g])
    );
  end

  assign reg_sel = addr[3:2];
  assign we      = sel & wrstb[0];
  assign wbits   = wrdata[N_BTN-1:0];

  always_comb begin
    rise_clr = '0;
    fall_clr = '0;
    mask_d   = mask_q;
    if (we) begin
      unique case (reg_sel)
        BTN_REG_RISE: rise_clr = wbits;
        BTN_REG_FALL: fall_clr = wbits;
        BTN_REG_MASK: mask_d   = wbits;
        default:      ;
      endcase
    end
    // A new edge outranks a same-cycle clear.
    rise_d = (rise_q & ~rise_clr) | rise_ev;
    fall_d = (fall_q & ~fall_clr) | fall_ev;
  end

  always_comb begin
    rd_bits = '0;
    unique case (reg_sel)
      BTN_REG_STATE: rd_bits = state;
      BTN_REG_RISE:  rd_bits = rise_q;
      BTN_REG_FALL:  rd_bits = fall_q;
      BTN_REG_MASK:  rd_bits = mask_q;
      default:       rd_bits = '0;
    endcase
    rddata_d = '0;
    if (sel) begin
      rddata_d[N_BTN-1:0] = rd_bits;
    end
    irq_d = |((rise_q | fall_q) & mask_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_q   <= '0;
      fall_q   <= '0;
      mask_q   <= '0;
      rddata_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      mask_q   <= mask_d;
      rddata_q <= rddata_d;
      irq_q    <= irq_d;
    end
  end

  assign rddata = rddata_q;
  assign irq    = irq_q;

endmodule
